// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 scanning multiplexer.
// Mode encodings, FSM state type and a width helper.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Never returns 0 so a select bus always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_scan_seq.sv
// Round-robin channel sequencer with per-channel dwell and wrap pulse.
// ch is the channel sampled this cycle (forced to 0 on restart).
module mux_scan_seq #(
    parameter int N       = 4,
    parameter int DWELL_W = 4,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               restart,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   ch,
    output logic               wrap
);

    logic [SEL_W-1:0]   ch_q;
    logic [DWELL_W-1:0] dc_q;
    logic [DWELL_W-1:0] dc_cur;
    logic               adv;
    logic               last;

    assign ch     = restart ? '0 : ch_q;
    assign dc_cur = restart ? '0 : dc_q;
    // Live compare: lowering dwell below dc advances on the next edge.
    assign adv    = (dc_cur >= dwell);
    assign last   = (ch == SEL_W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q <= '0;
            dc_q <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (run) begin
                if (adv) begin
                    dc_q <= '0;
                    ch_q <= last ? '0 : ch + SEL_W'(1);
                    wrap <= last;
                end else begin
                    dc_q <= dc_cur + DWELL_W'(1);
                    ch_q <= ch;
                end
            end else if (restart) begin
                ch_q <= '0;
                dc_q <= '0;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N-channel W-bit multiplexer with registered output, direct or scan mode.
// Output y/y_ch/y_valid reflect inputs sampled at the same clock edge.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int DWELL_W = 4,
    localparam int SEL_W  = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*W-1:0]     din,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               en,
    output logic [W-1:0]       y,
    output logic               y_valid,
    output logic [SEL_W-1:0]   y_ch,
    output logic               wrap
);

    state_t           state;
    state_t           nxt;
    logic             resume;
    logic             run;
    logic             restart;
    logic [SEL_W-1:0] ch;
    logic [SEL_W-1:0] idx;
    logic             idx_ok;
    logic [W-1:0]     mux_data;

    always_comb begin
        nxt = IDLE;
        if (en) begin
            nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end
    end

    // Scan resumes only if it was interrupted by idle with mode kept high.
    assign run     = (nxt == SCAN);
    assign restart = (nxt == DIRECT)
                   || (run && (state != SCAN) && !resume);

    mux_scan_seq #(
        .N       (N),
        .DWELL_W (DWELL_W),
        .SEL_W   (SEL_W)
    ) u_seq (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .restart (restart),
        .dwell   (dwell),
        .ch      (ch),
        .wrap    (wrap)
    );

    assign idx    = (nxt == SCAN) ? ch : sel;
    assign idx_ok = (int'(idx) < N);

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SEL_W'(k)) begin
                mux_data = din[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            resume  <= 1'b0;
            y       <= '0;
            y_valid <= 1'b0;
            y_ch    <= '0;
        end else begin
            state <= nxt;
            if (run) begin
                resume <= 1'b1;
            end else if (nxt == DIRECT || mode == MODE_DIRECT) begin
                resume <= 1'b0;
            end
            unique case (nxt)
                IDLE: begin
                    y_valid <= 1'b0;
                end
                DIRECT: begin
                    y       <= mux_data;
                    y_ch    <= sel;
                    y_valid <= idx_ok;
                end
                SCAN: begin
                    y       <= mux_data;
                    y_ch    <= ch;
                    y_valid <= 1'b1;
                end
            endcase
        end
    end

endmodule
